// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: states, prices,
// accepted coin denominations and stock limits.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_DISPENSE,
        ST_CHANGE
    } state_t;

    localparam int         N_ITEMS    = 4;
    localparam int         N_COINS    = 6;
    localparam logic [7:0] MAX_CREDIT = 8'd200;
    localparam logic [3:0] STOCK_INIT = 4'd8;
    localparam logic [3:0] STOCK_MAX  = 4'd15;

    localparam logic [7:0] PRICE [N_ITEMS] = '{8'd5, 8'd10, 8'd20, 8'd50};

    // Descending order so the same list serves acceptance and greedy change.
    localparam logic [7:0] COIN_LIST [N_COINS] = '{8'd50, 8'd20, 8'd10, 8'd5, 8'd2, 8'd1};

    function automatic logic coin_ok(input logic [7:0] c);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < N_COINS; i++) begin
            if (c == COIN_LIST[i]) ok = 1'b1;
        end
        return ok;
    endfunction

    // Largest denomination not exceeding amt; 0 when amt is 0.
    function automatic logic [7:0] greedy_coin(input logic [7:0] amt);
        logic [7:0] c;
        c = 8'd0;
        for (int i = N_COINS - 1; i >= 0; i--) begin
            if (COIN_LIST[i] <= amt) c = COIN_LIST[i];
        end
        return c;
    endfunction

endpackage

// File: rtl/change_payout.sv
// Pays out a refund one greedy coin at a time over a valid/ready handshake.
// start loads the amount to pay; take/done report each handshake to the owner.
module change_payout
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       chg_ready,
    output logic       chg_valid,
    output logic [7:0] chg_coin,
    output logic       take,
    output logic       done
);

    logic [7:0] remain;
    logic [7:0] remain_n;

    assign take     = chg_valid & chg_ready;
    assign remain_n = remain - chg_coin;
    assign done     = take && (remain_n == 8'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remain    <= 8'd0;
            chg_valid <= 1'b0;
            chg_coin  <= 8'd0;
        end else if (start) begin
            remain    <= amount;
            chg_valid <= (amount != 8'd0);
            chg_coin  <= greedy_coin(amount);
        end else if (take) begin
            remain    <= remain_n;
            chg_valid <= (remain_n != 8'd0);
            chg_coin  <= greedy_coin(remain_n);
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: credit accumulation, selection checks, dispense
// handshake, stock tracking, and change payout via change_payout.
//
//   state       | meaning
//   ST_IDLE     | no credit held, waiting for coins
//   ST_CREDIT   | credit held, waiting for selection or cancel
//   ST_DISPENSE | disp_req high until disp_ack
//   ST_CHANGE   | paying remaining credit back as coins
module vend_ctrl
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [7:0] coin_in,
    input  logic       sel_valid,
    input  logic [1:0] select,
    input  logic       cancel,
    input  logic [3:0] restock,
    output logic       disp_req,
    output logic [1:0] disp_item,
    input  logic       disp_ack,
    output logic       chg_valid,
    output logic [7:0] chg_coin,
    input  logic       chg_ready,
    output logic [7:0] credit,
    output logic [3:0] item_dispensed,
    output logic       coin_reject,
    output logic       err_sold_out,
    output logic       err_funds,
    output logic       busy
);

    state_t st, st_n;
    logic [N_ITEMS-1:0][3:0] stock;
    logic [7:0] credit_n;
    logic [8:0] coin_sum;
    logic       coin_fits, sel_sold, sel_funds, sel_go, cancel_go, leaving;
    logic       disp_req_n;
    logic [1:0] disp_item_n;
    logic [3:0] dispensed_n, stock_dec;
    logic       reject_n, sold_n, funds_n;
    logic       pay_start, pay_take, pay_done;

    change_payout u_payout (
        .clk       (clk),
        .rst       (rst),
        .start     (pay_start),
        .amount    (credit_n),
        .chg_ready (chg_ready),
        .chg_valid (chg_valid),
        .chg_coin  (chg_coin),
        .take      (pay_take),
        .done      (pay_done)
    );

    always_comb begin
        st_n        = st;
        credit_n    = credit;
        disp_req_n  = disp_req;
        disp_item_n = disp_item;
        dispensed_n = 4'd0;
        stock_dec   = 4'd0;
        reject_n    = 1'b0;
        sold_n      = 1'b0;
        funds_n     = 1'b0;
        pay_start   = 1'b0;
        leaving     = 1'b0;
        coin_sum    = {1'b0, credit} + {1'b0, coin_in};
        coin_fits   = coin_ok(coin_in) && (coin_sum <= {1'b0, MAX_CREDIT});
        // Selection is judged on pre-coin credit; stock is checked before funds.
        sel_sold    = sel_valid && (stock[select] == 4'd0);
        sel_funds   = sel_valid && !sel_sold && (credit < PRICE[select]);
        sel_go      = sel_valid && !sel_sold && !sel_funds;
        cancel_go   = cancel && (st == ST_CREDIT) && !sel_go;

        case (st)
            ST_IDLE, ST_CREDIT: begin
                sold_n  = sel_sold;
                funds_n = sel_funds;
                leaving = sel_go || cancel_go;
                if (sel_go) begin
                    st_n        = ST_DISPENSE;
                    disp_req_n  = 1'b1;
                    disp_item_n = select;
                end else if (cancel_go) begin
                    st_n      = ST_CHANGE;
                    pay_start = 1'b1;
                end
                // A coin arriving as we go busy is refused rather than banked.
                if (coin_valid) begin
                    if (!leaving && coin_fits) credit_n = coin_sum[7:0];
                    else                       reject_n = 1'b1;
                end
                if (!leaving) st_n = (credit_n != 8'd0) ? ST_CREDIT : ST_IDLE;
            end
            ST_DISPENSE: begin
                reject_n = coin_valid;
                if (disp_ack) begin
                    stock_dec[disp_item]   = 1'b1;
                    dispensed_n[disp_item] = 1'b1;
                    disp_req_n             = 1'b0;
                    credit_n               = credit - PRICE[disp_item];
                    if (credit_n != 8'd0) begin
                        st_n      = ST_CHANGE;
                        pay_start = 1'b1;
                    end else begin
                        st_n = ST_IDLE;
                    end
                end
            end
            default: begin
                reject_n = coin_valid;
                if (pay_take) credit_n = credit - chg_coin;
                if (pay_done) st_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st             <= ST_IDLE;
            credit         <= 8'd0;
            disp_req       <= 1'b0;
            disp_item      <= 2'd0;
            item_dispensed <= 4'd0;
            coin_reject    <= 1'b0;
            err_sold_out   <= 1'b0;
            err_funds      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            st             <= st_n;
            credit         <= credit_n;
            disp_req       <= disp_req_n;
            disp_item      <= disp_item_n;
            item_dispensed <= dispensed_n;
            coin_reject    <= reject_n;
            err_sold_out   <= sold_n;
            err_funds      <= funds_n;
            busy           <= (st_n == ST_DISPENSE) || (st_n == ST_CHANGE);
        end
    end

    // Restock wins over a same-cycle vend decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_INIT;
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (restock[i])        stock[i] <= STOCK_MAX;
                else if (stock_dec[i]) stock[i] <= stock[i] - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid, sel_valid, cancel, disp_ack, chg_ready;
    logic [7:0] coin_in;
    logic [1:0] select;
    logic [3:0] restock;
    logic       disp_req, chg_valid, coin_reject, err_sold_out, err_funds, busy;
    logic [1:0] disp_item;
    logic [7:0] chg_coin, credit;
    logic [3:0] item_dispensed;

    int vectors = 0;
    int miscompares = 0;

    vend_ctrl dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_in(coin_in),
        .sel_valid(sel_valid), .select(select), .cancel(cancel), .restock(restock),
        .disp_req(disp_req), .disp_item(disp_item), .disp_ack(disp_ack),
        .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ready(chg_ready),
        .credit(credit), .item_dispensed(item_dispensed), .coin_reject(coin_reject),
        .err_sold_out(err_sold_out), .err_funds(err_funds), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: credit, stock counts, an outstanding vend, and the refund as a queue of coins.
    int   prices[4] = '{5, 10, 20, 50};
    int   denoms[6] = '{50, 20, 10, 5, 2, 1};
    int   pool[10]  = '{1, 2, 5, 10, 20, 50, 3, 7, 100, 0};
    int   m_credit;
    int   m_stock[4];
    bit   m_vending;
    int   m_item;
    int   m_refund[$];
    logic [3:0] e_disp;
    bit   e_rej, e_sold, e_funds;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic plan_refund(input int amt);
        m_refund.delete();
        while (amt > 0) begin
            for (int k = 0; k < 6; k++) begin
                if (denoms[k] <= amt) begin
                    m_refund.push_back(denoms[k]);
                    amt -= denoms[k];
                    break;
                end
            end
        end
    endtask

    task automatic m_reset();
        m_credit  = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 8;
        m_vending = 0;
        m_item    = 0;
        m_refund.delete();
        e_disp = 4'd0; e_rej = 0; e_sold = 0; e_funds = 0;
    endtask

    task automatic m_step();
        bit was_busy, leave;
        was_busy = m_vending || (m_refund.size() != 0);
        leave    = 0;
        e_disp = 4'd0; e_rej = 0; e_sold = 0; e_funds = 0;
        if (m_vending) begin
            if (disp_ack) begin
                m_stock[m_item] -= 1;
                m_credit        -= prices[m_item];
                e_disp           = 4'b0001 << m_item;
                m_vending        = 0;
                plan_refund(m_credit);
            end
        end else if (m_refund.size() != 0) begin
            if (chg_ready) m_credit -= m_refund.pop_front();
        end else begin
            if (sel_valid) begin
                if (m_stock[select] == 0)             e_sold = 1;
                else if (m_credit < prices[select])   e_funds = 1;
                else begin
                    m_vending = 1;
                    m_item    = int'(select);
                    leave     = 1;
                end
            end
            if (!leave && cancel && m_credit > 0) begin
                plan_refund(m_credit);
                leave = 1;
            end
        end
        if (coin_valid) begin
            if (was_busy || leave || !(int'(coin_in) inside {1, 2, 5, 10, 20, 50}) ||
                m_credit + int'(coin_in) > 200)
                e_rej = 1;
            else
                m_credit += int'(coin_in);
        end
        for (int i = 0; i < 4; i++) if (restock[i]) m_stock[i] = 15;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) m_reset();
        else      m_step();
    end

    always @(negedge clk) begin
        chk("credit", credit, m_credit);
        chk("disp_req", disp_req, m_vending);
        chk("disp_item", disp_item, m_item);
        chk("chg_valid", chg_valid, m_refund.size() != 0);
        chk("chg_coin", chg_coin, (m_refund.size() != 0) ? m_refund[0] : 0);
        chk("item_dispensed", item_dispensed, e_disp);
        chk("coin_reject", coin_reject, e_rej);
        chk("err_sold_out", err_sold_out, e_sold);
        chk("err_funds", err_funds, e_funds);
        chk("busy", busy, m_vending || (m_refund.size() != 0));
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        coin_valid = 0; coin_in = 0; sel_valid = 0; select = 0;
        cancel = 0; restock = 0; disp_ack = 0; chg_ready = 0;
    endtask

    task automatic coin(input int v);
        coin_valid = 1; coin_in = 8'(v); cyc(); coin_valid = 0;
    endtask

    task automatic sel(input int s);
        sel_valid = 1; select = 2'(s); cyc(); sel_valid = 0;
    endtask

    task automatic ack();
        disp_ack = 1; cyc(); disp_ack = 0;
    endtask

    task automatic pay(input int n);
        chg_ready = 1; cyc(n); chg_ready = 0;
    endtask

    task automatic drain_item1(input string tag);
        for (int v = 0; v < 8; v++) begin
            coin(10); sel(1); ack();
            chk({tag, "_vend"}, item_dispensed, 4'b0010);
        end
        coin(10); sel(1);
        chk({tag, "_sold_out"}, err_sold_out, 1);
        chk({tag, "_credit_kept"}, credit, 10);
    endtask

    initial begin
        rst = 1'b0;
        clr();
        m_reset();
        cyc(3);
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        cyc();

        // coin 10, item 0, ack on the third dispense cycle
        coin(10);
        chk("s1_credit", credit, 10);
        sel(0);
        chk("s1_req_c1", disp_req, 1); cyc();
        chk("s1_req_c2", disp_req, 1); cyc();
        chk("s1_req_c3", disp_req, 1);
        ack();
        chk("s1_dispensed", item_dispensed, 4'b0001);
        chk("s1_req_drop", disp_req, 0);
        chk("s1_chg_coin", chg_coin, 5);
        chk("s1_credit_after", credit, 5);
        pay(1);
        chk("s1_credit_zero", credit, 0);
        chk("s1_chg_done", chg_valid, 0);
        chk("s1_idle", busy, 0);

        // 50+20, item 2, stalled hopper
        coin(50); coin(20);
        chk("s2_credit70", credit, 70);
        sel(2); ack();
        chk("s2_credit50", credit, 50);
        cyc(2);
        chk("s2_stall_coin", chg_coin, 50);
        chk("s2_stall_valid", chg_valid, 1);
        pay(1);
        chk("s2_credit0", credit, 0);
        chk("s2_no_more", chg_valid, 0);

        // insufficient funds, then cancel
        coin(20); sel(3);
        chk("s3_funds", err_funds, 1);
        chk("s3_credit", credit, 20);
        cancel = 1; cyc(); cancel = 0;
        chk("s3_refund", chg_coin, 20);
        pay(1);
        chk("s3_idle", busy, 0);

        // sell out item 1, restock, vend again
        drain_item1("s4");
        restock = 4'b0010; cyc(); restock = 0;
        sel(1);
        chk("s4_restock_go", disp_req, 1);
        ack();
        chk("s4_restock_vend", item_dispensed, 4'b0010);
        chk("s4_credit", credit, 0);

        // same-cycle coin and selection
        coin_valid = 1; coin_in = 5; sel_valid = 1; select = 0; cyc(); clr();
        chk("s5_funds_precoin", err_funds, 1);
        chk("s5_coin_kept", credit, 5);
        coin_valid = 1; coin_in = 10; sel_valid = 1; select = 0; cyc(); clr();
        chk("s5_coin_refused", coin_reject, 1);
        chk("s5_vend_go", disp_req, 1);
        ack();

        // rejected coins
        coin(3);
        chk("s6_bad_denom", coin_reject, 1);
        chk("s6_credit0", credit, 0);
        coin(10); sel(0); coin(50);
        chk("s6_busy_reject", coin_reject, 1);
        chk("s6_credit10", credit, 10);
        ack(); pay(1);
        repeat (4) coin(50);
        chk("s6_credit200", credit, 200);
        coin(1);
        chk("s6_over_max", coin_reject, 1);
        chk("s6_credit_kept", credit, 200);
        cancel = 1; cyc(); cancel = 0;
        pay(4);
        chk("s6_refund_done", credit, 0);

        // reset mid-change
        coin(20); sel(1); ack();
        chk("s7_in_change", chg_valid, 1);
        chk("s7_disp_item", disp_item, 1);
        #2 rst = 1'b0;
        #1;
        chk("s7_rst_credit", credit, 0);
        chk("s7_rst_chg_valid", chg_valid, 0);
        chk("s7_rst_chg_coin", chg_coin, 0);
        chk("s7_rst_busy", busy, 0);
        chk("s7_rst_disp_item", disp_item, 0);
        chk("s7_rst_disp_req", disp_req, 0);
        cyc();
        rst = 1'b1;
        cyc();
        drain_item1("s7");
        cancel = 1; cyc(); cancel = 0;
        pay(1);

        // randomized traffic
        repeat (4000) begin
            coin_valid = ($urandom_range(0, 99) < 30);
            coin_in    = 8'(pool[$urandom_range(0, 9)]);
            sel_valid  = ($urandom_range(0, 99) < 20);
            select     = 2'($urandom_range(0, 3));
            cancel     = ($urandom_range(0, 99) < 6);
            restock    = ($urandom_range(0, 99) < 3) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            disp_ack   = ($urandom_range(0, 99) < 40);
            chg_ready  = ($urandom_range(0, 99) < 50);
            cyc();
        end
        clr();
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; no other clock or reset inputs.
REQ-002 SHALL have port `clk`: input, 1 bit, rising-edge clock.
REQ-003 SHALL have port `rst`: input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port `coin_valid`: input, 1 bit, one-cycle coin-insert strobe.
REQ-005 SHALL have port `coin_in`: input, 8 bits, coin value in ₹, qualified by `coin_valid`.
REQ-006 SHALL have port `sel_valid`: input, 1 bit, one-cycle selection strobe.
REQ-007 SHALL have port `select`: input, 2 bits, item code: 0 chocolate, 1 chips, 2 cold drink, 3 ice cream.
REQ-008 SHALL have port `cancel`: input, 1 bit, refund request strobe.
REQ-009 SHALL have port `restock`: input, 4 bits, one-hot per item; sets that item's stock to 15.
REQ-010 SHALL have port `disp_req`: output, 1 bit, dispenser request.
REQ-011 SHALL have port `disp_item`: output, 2 bits, item code for the dispenser.
REQ-012 SHALL have port `disp_ack`: input, 1 bit, dispenser done.
REQ-013 SHALL have port `chg_valid`: output, 1 bit, change coin offered.
REQ-014 SHALL have port `chg_coin`: output, 8 bits, value of the offered change coin in ₹.
REQ-015 SHALL have port `chg_ready`: input, 1 bit, coin accepted by the payout hopper.
REQ-016 SHALL have port `credit`: output, 8 bits, current credit in ₹.
REQ-017 SHALL have port `item_dispensed`: output, 4 bits, one-hot, pulses for one cycle on completed vend.
REQ-018 SHALL have port `coin_reject`: output, 1 bit, one-cycle pulse.
REQ-019 SHALL have port `err_sold_out`: output, 1 bit, one-cycle pulse.
REQ-020 SHALL have port `err_funds`: output, 1 bit, one-cycle pulse.
REQ-021 SHALL have port `busy`: output, 1 bit, high in DISPENSE or CHANGE.

Function
REQ-022 SHALL implement states IDLE, CREDIT, DISPENSE, CHANGE.
REQ-023 SHALL add `coin_in` to `credit` on the next edge only when not busy, the coin is in {1,2,5,10,20,50} and credit+coin ≤ 200; otherwise it SHALL pulse `coin_reject` and leave `credit` unchanged.
REQ-024 SHALL move from IDLE to CREDIT when `credit` becomes non-zero.
REQ-025 SHALL, on `sel_valid` in IDLE/CREDIT, check stock first: stock 0 -> pulse `err_sold_out`, state unchanged; otherwise credit < price -> pulse `err_funds`, state unchanged; otherwise enter DISPENSE.
REQ-026 SHALL use prices 5/10/20/50 for items 0/1/2/3.
REQ-027 SHALL, in DISPENSE, hold `disp_req`=1 and `disp_item` stable until the cycle `disp_ack`=1.
REQ-028 SHALL, on the `disp_ack` cycle: decrement that item's stock, reduce `credit` by the price, pulse `item_dispensed`, and drop `disp_req` on the next edge.
REQ-029 SHALL, after the `disp_ack` edge, enter CHANGE if the remaining credit > 0, else IDLE.
REQ-030 SHALL, on `cancel` in CREDIT, enter CHANGE with the full credit.
REQ-031 SHALL ignore `cancel` in IDLE, DISPENSE and CHANGE.
REQ-032 SHALL, in CHANGE, offer greedy denominations 50,20,10,5,2,1 (largest ≤ remaining credit), one per `chg_valid`/`chg_ready` handshake.
REQ-033 SHALL hold `chg_coin` stable while `chg_valid`=1 and `chg_ready`=0.
REQ-034 SHALL subtract `chg_coin` from `credit` on each handshake.
REQ-035 SHALL enter IDLE at the handshake that zeroes `credit`, with `chg_valid`=0 on the following cycle.
REQ-036 SHALL reject (`coin_reject`) a `coin_valid` arriving while `busy`=1.
REQ-037 SHALL ignore `sel_valid` while `busy`=1.
REQ-038 SHALL, when `coin_valid` and `sel_valid` occur in the same cycle, evaluate the selection against the pre-coin credit and still apply the coin; if the selection goes to DISPENSE, the coin is rejected.
REQ-039 SHALL give `restock` priority over a same-cycle stock decrement; the result is 15.
REQ-040 SHALL treat `disp_ack` outside DISPENSE and `chg_ready` outside CHANGE as don't-care, with no state change.

Reset
REQ-041 SHALL, on `rst`=0, enter IDLE asynchronously and set `credit`=0, `disp_req`=0, `disp_item`=0, `chg_valid`=0, `chg_coin`=0, `item_dispensed`=0, `coin_reject`=0, `err_sold_out`=0, `err_funds`=0, `busy`=0, and every stock count = 8.
REQ-042 SHALL discard any credit held when reset occurs mid-DISPENSE or mid-CHANGE, with no refund.
REQ-043 SHALL register all outputs; none are combinational from inputs.

Structure
REQ-044 SHALL place in shared package `vend_pkg`: the state enum, item price table, accepted-coin list, MAX_CREDIT=200, STOCK_INIT=8, STOCK_MAX=15.
REQ-045 SHALL instantiate one sub-module, `change_payout`, which holds the greedy denomination selection and the change handshake.
REQ-046 SHALL keep the FSM, credit accumulator and stock counters in `vend_ctrl`.

Verification
REQ-047 SHALL cover: coin 10, select 0, ack after 3 cycles -> `disp_req` held 3 cycles, `item_dispensed`=0001, one change coin of 5, `credit`=0, IDLE.
REQ-048 SHALL cover: coins 50+20, select 2, `chg_ready` low 2 cycles then high -> coins 50 (held stable while stalled), then none; `credit` 70→50→0.
REQ-049 SHALL cover: coin 20, select 3 -> `err_funds` pulse, `credit` stays 20; then cancel -> change coin 20, IDLE.
REQ-050 SHALL cover: stock of item 1 driven to 0 by 8 vends, then select 1 -> `err_sold_out`; restock 0010 -> next vend succeeds.
REQ-051 SHALL cover: coin 3, coin 50 during DISPENSE, and coins totalling 200 then coin 1 -> each gets a `coin_reject` pulse with `credit` unchanged.
REQ-052 SHALL cover: `rst` low mid-CHANGE -> all outputs are at reset values in the same cycle, and stock counts = 8.
